bin_to_bcd_display: RTL and testbench

//   Sequential double-dabble converter: turns an unsigned binary value into DIGITS
//   4-bit BCD digits plus per-digit blank flags for leading-zero suppression.

---
 rtl/bin_to_bcd_if.sv | 18 +
 rtl/bin_to_bcd_display.sv | 116 +++++++++++
 tb/tb_bin_to_bcd_display.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_if.sv
// Bundle of control, data and result signals for bin_to_bcd_display.
//   master: requester side (drives start/bin/lz_en, reads results)
//   slave : converter side (reads request, drives busy/done/digits/blank)
interface bin_to_bcd_if #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
);
  logic                  start;
  logic [IN_WIDTH-1:0]   bin;
  logic                  lz_en;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     blank;

  modport master (output start, bin, lz_en, input busy, done, digits, blank);
  modport slave  (input start, bin, lz_en, output busy, done, digits, blank);
endinterface

// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble binary -> BCD converter with leading-zero blanking,
// feeding per-digit 7-segment decoders. Results are registered and held
// between conversions.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus.start  conversion request (sampled only while idle)
//   bus.bin    unsigned input, captured on the accept cycle
//   bus.lz_en  1 = blank leading zeros (sampled in FINISH)
//   bus.busy   conversion in progress
//   bus.done   one-cycle pulse when digits/blank update
//   bus.digits BCD result, digit 0 in [3:0]
//   bus.blank  per-digit blank flag (1 = display off)
module bin_to_bcd_display #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
) (
  input  logic         clk,
  input  logic         rst,
  bin_to_bcd_if.slave  bus
);
  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] shreg_q, shreg_d;
  logic [SW-1:0]       scratch_q, scratch_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [SW-1:0]       digits_q, digits_d;
  logic [DIGITS-1:0]   blank_q, blank_d;

  logic [SW-1:0]       adj;
  logic [DIGITS-1:0]   blank_calc;
  logic                zero_above;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    digits_d  = digits_q;
    blank_d   = blank_q;

    // Add-3 correction on every digit, applied before the shift.
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end

    // Digit i is blank when it and every higher digit are zero; digit 0 never
    // blanks so a zero value still shows one "0".
    blank_calc = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (scratch_q[4*i +: 4] == 4'd0);
      blank_calc[i] = bus.lz_en && zero_above;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d   = bus.bin;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        {scratch_d, shreg_d} = {adj[SW-2:0], shreg_q, 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(IN_WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        digits_d = scratch_q;
        blank_d  = blank_calc;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      digits_q  <= '0;
      blank_q   <= '1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.digits = digits_q;
  assign bus.blank  = blank_q;
endmodule

// File: tb/tb_bin_to_bcd_display.sv
module tb_bin_to_bcd_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  bin_to_bcd_if #(.IN_WIDTH(16), .DIGITS(5)) b ();

  bin_to_bcd_display #(.IN_WIDTH(16), .DIGITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  // Reference: decimal digits by plain division.
  function automatic logic [19:0] ref_digits(input int v);
    int t = v;
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Digit i and everything above it are zero exactly when v < 10^i.
  function automatic logic [4:0] ref_blank(input int v, input bit lz);
    logic [4:0] r = '0;
    int p = 1;
    for (int i = 1; i < 5; i++) begin
      p = p * 10;
      r[i] = lz && (v < p);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Wait for done after the accept edge; returns cycles since accept (18 expected).
  task automatic wait_done(input int start_cyc, output int cyc);
    cyc = start_cyc;
    while (b.done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic convert(input int v, input bit lz, input string tag);
    int cyc;
    logic [19:0] exp_d;
    @(negedge clk);
    b.start = 1'b1; b.bin = 16'(v); b.lz_en = lz;
    @(posedge clk); #1;
    b.start = 1'b0; b.bin = 16'($urandom);
    chk({tag, "_busy"}, 32'(b.busy), 32'd1);
    wait_done(1, cyc);
    exp_d = ref_digits(v);
    chk({tag, "_lat"}, 32'(cyc), 32'd18);
    chk({tag, "_dig"}, 32'(b.digits), 32'(exp_d));
    chk({tag, "_blk"}, 32'(b.blank), 32'(ref_blank(v, lz)));
    chk({tag, "_busy_done"}, 32'(b.busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(b.done), 32'd0);
    chk({tag, "_hold"}, 32'(b.digits), 32'(exp_d));
  endtask

  initial begin
    int cyc;
    int ndone;
    bit exp_done;
    b.start = 1'b0; b.bin = '0; b.lz_en = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(b.busy), 32'd0);
    chk("rst_done", 32'(b.done), 32'd0);
    chk("rst_dig", 32'(b.digits), 32'd0);
    chk("rst_blk", 32'(b.blank), 32'h1f);
    rst = 1'b0;

    // Directed cases
    convert(0, 1'b1, "zero");
    convert(65535, 1'b1, "max");
    convert(1234, 1'b1, "v1234_lz");
    convert(1234, 1'b0, "v1234_nolz");
    convert(9, 1'b1, "v9");
    convert(10, 1'b1, "v10");
    convert(9999, 1'b1, "v9999");
    convert(10000, 1'b1, "v10000");

    // start held high: back-to-back conversions every 18 clocks
    @(negedge clk);
    b.start = 1'b1; b.bin = 16'd42; b.lz_en = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 54; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      exp_done = (c % 18 == 0);
      chk("b2b_done", 32'(b.done), 32'(exp_done));
      chk("b2b_busy", 32'(b.busy), 32'(!exp_done));
      if (exp_done) chk("b2b_dig", 32'(b.digits), 32'h42);
    end
    b.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_idle", 32'(b.busy), 32'd0);

    // start while busy is ignored
    @(negedge clk);
    b.start = 1'b1; b.bin = 16'd999; b.lz_en = 1'b1;
    @(posedge clk); #1;
    b.start = 1'b0;
    cyc = 1;
    repeat (4) begin @(posedge clk); #1; cyc++; end
    b.start = 1'b1; b.bin = 16'd7;
    @(posedge clk); #1; cyc++;
    b.start = 1'b0;
    wait_done(cyc, cyc);
    chk("ign_lat", 32'(cyc), 32'd18);
    chk("ign_dig", 32'(b.digits), 32'h999);
    chk("ign_blk", 32'(b.blank), 32'(5'b11000));
    repeat (3) @(posedge clk);
    #1;
    chk("ign_noqueue", 32'(b.busy), 32'd0);

    // Reset mid-conversion
    @(negedge clk);
    b.start = 1'b1; b.bin = 16'd500; b.lz_en = 1'b1;
    @(posedge clk); #1;
    b.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(b.busy), 32'd0);
    chk("mid_rst_dig", 32'(b.digits), 32'd0);
    chk("mid_rst_blk", 32'(b.blank), 32'h1f);
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (b.done === 1'b1) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'd0);
    chk("mid_rst_hold", 32'(b.digits), 32'd0);
    convert(8, 1'b1, "after_rst");

    // Randomized values against the reference model
    for (int i = 0; i < 20; i++) begin
      convert(int'($urandom_range(0, 65535)), 1'($urandom), "rand");
    end
    for (int i = 0; i < 6; i++) begin
      convert(int'($urandom_range(0, 120)), 1'b1, "rand_small");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
